// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: groups the MEM-stage request bus and the backing-memory
// req/ack port of the data cache controller.
//
// Memory handshake: the cache raises mem_req with mem_we/mem_addr/mem_wdata
// and holds all of them constant until the memory returns a one-cycle
// mem_ack. The transfer completes on the rising edge where mem_req and
// mem_ack are both high. mem_req drops (or moves to the next transfer) in
// the following cycle. An ack seen while mem_req is low means nothing.
interface dcache_ctrl_if #(
    parameter int ADDR_W = 22
);
    logic              re;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              cache_hit;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    // Environment side: MEM stage plus backing memory.
    modport master (
        output re, we, addr, wdata, mem_rdata, mem_ack,
        input  rdata, cache_hit, stall, mem_req, mem_we, mem_addr, mem_wdata
    );

    // Cache controller side.
    modport slave (
        input  re, we, addr, wdata, mem_rdata, mem_ack,
        output rdata, cache_hit, stall, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache with
// one-word lines. Hits complete combinationally in IDLE. A miss stalls the
// pipeline, writes back a dirty victim, then refills the line.
// Optional feature macro: DCACHE_FLUSH_EN adds flush/flush_done and a FLUSH
// state that writes back every dirty line while keeping it valid.
module dcache_ctrl #(
    parameter int LINES  = 16,
    parameter int ADDR_W = 22
) (
    input  logic               clk,
    input  logic               rst_n,
    dcache_ctrl_if.slave       bus,
`ifdef DCACHE_FLUSH_EN
    input  logic               flush,
    output logic               flush_done,
`endif
    output logic [1:0]         state_dbg_o
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
`ifdef DCACHE_FLUSH_EN
        , ST_FLUSH   = 2'd3
`endif
    } state_e;

    state_e            state_q;
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [31:0]       data_q [LINES];
    logic [ADDR_W-1:0] miss_addr_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
`ifdef DCACHE_FLUSH_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);
    logic [IDX_W-1:0]  flush_idx_q;
    logic              flushing_q;
    logic              flush_done_q;
`endif

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  miss_idx;
    logic [TAG_W-1:0]  miss_tag;
    logic              access;
    logic              line_hit;
    logic              flush_req;
    logic              hit;

    // Address slicing and hit detection; a pending flush outranks loads/stores.
    always_comb begin
        req_idx   = bus.addr[IDX_W-1:0];
        req_tag   = bus.addr[ADDR_W-1:IDX_W];
        miss_idx  = miss_addr_q[IDX_W-1:0];
        miss_tag  = miss_addr_q[ADDR_W-1:IDX_W];
        access    = bus.re | bus.we;
        line_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
        flush_req = 1'b0;
`ifdef DCACHE_FLUSH_EN
        flush_req = flush;
`endif
        hit = rst_n && (state_q == ST_IDLE) && !flush_req && access && line_hit;
    end

    assign bus.cache_hit = hit;
    assign bus.rdata     = (hit && bus.re) ? data_q[req_idx] : 32'h0;
    assign bus.stall     = rst_n && ((state_q != ST_IDLE) || flush_req ||
                                     (access && !line_hit));
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign state_dbg_o   = state_q;
`ifdef DCACHE_FLUSH_EN
    assign flush_done    = flush_done_q;
`endif

    // Controller FSM together with line storage and registered memory-port outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            miss_addr_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
`ifdef DCACHE_FLUSH_EN
            flush_idx_q  <= '0;
            flushing_q   <= 1'b0;
            flush_done_q <= 1'b0;
`endif
        end else begin
`ifdef DCACHE_FLUSH_EN
            flush_done_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
`ifdef DCACHE_FLUSH_EN
                    if (flush) begin
                        state_q     <= ST_FLUSH;
                        flush_idx_q <= '0;
                    end else
`endif
                    if (access) begin
                        if (line_hit) begin
                            // Store (or simultaneous load+store) updates the line in place.
                            if (bus.we) begin
                                data_q[req_idx]  <= bus.wdata;
                                dirty_q[req_idx] <= 1'b1;
                            end
                        end else begin
                            miss_addr_q <= bus.addr;
                            mem_req_q   <= 1'b1;
                            if (valid_q[req_idx] && dirty_q[req_idx]) begin
                                state_q     <= ST_WRITEBACK;
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= {tag_q[req_idx], req_idx};
                                mem_wdata_q <= data_q[req_idx];
                            end else begin
                                state_q    <= ST_ALLOCATE;
                                mem_we_q   <= 1'b0;
                                mem_addr_q <= bus.addr;
                            end
                        end
                    end
                end

                ST_WRITEBACK: begin
                    if (bus.mem_ack) begin
`ifdef DCACHE_FLUSH_EN
                        if (flushing_q) begin
                            dirty_q[flush_idx_q] <= 1'b0;
                            flushing_q           <= 1'b0;
                            mem_req_q            <= 1'b0;
                            mem_we_q             <= 1'b0;
                            if (flush_idx_q == LAST_IDX) begin
                                flush_done_q <= 1'b1;
                                state_q      <= ST_IDLE;
                            end else begin
                                flush_idx_q <= flush_idx_q + IDX_W'(1);
                                state_q     <= ST_FLUSH;
                            end
                        end else
`endif
                        begin
                            // Refill follows back-to-back with no idle cycle.
                            state_q    <= ST_ALLOCATE;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= miss_addr_q;
                        end
                    end
                end

                ST_ALLOCATE: begin
                    if (bus.mem_ack) begin
                        data_q[miss_idx]  <= bus.mem_rdata;
                        tag_q[miss_idx]   <= miss_tag;
                        valid_q[miss_idx] <= 1'b1;
                        dirty_q[miss_idx] <= 1'b0;
                        mem_req_q         <= 1'b0;
                        state_q           <= ST_IDLE;
                    end
                end

`ifdef DCACHE_FLUSH_EN
                ST_FLUSH: begin
                    if (valid_q[flush_idx_q] && dirty_q[flush_idx_q]) begin
                        state_q     <= ST_WRITEBACK;
                        flushing_q  <= 1'b1;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {tag_q[flush_idx_q], flush_idx_q};
                        mem_wdata_q <= data_q[flush_idx_q];
                    end else if (flush_idx_q == LAST_IDX) begin
                        flush_done_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else begin
                        flush_idx_q <= flush_idx_q + IDX_W'(1);
                    end
                end
`endif

                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed test of dcache_ctrl. Covers reset values, clean
// and dirty misses, store hits, a slow memory ack, a spurious ack, reset in
// the middle of a refill and, with DCACHE_FLUSH_EN, a full flush.
module tb_dcache_ctrl;
    localparam int LINES  = 16;
    localparam int ADDR_W = 22;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;
`ifdef DCACHE_FLUSH_EN
    logic       flush;
    logic       flush_done;
`endif

    dcache_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    dcache_ctrl #(.LINES(LINES), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
`ifdef DCACHE_FLUSH_EN
        .flush       (flush),
        .flush_done  (flush_done),
`endif
        .state_dbg_o (state_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Write-back addresses seen on the memory port and the ones we expect.
    logic [31:0] wb_q  [$];
    logic [31:0] exp_q [$];

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Log every completed write-back transfer.
    always @(posedge clk) begin
        if (rst_n && bus.mem_req && bus.mem_ack && bus.mem_we)
            wb_q.push_back(32'(bus.mem_addr));
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic re, input logic we, input logic [31:0] a,
                             input logic [31:0] d);
        bus.re    = re;
        bus.we    = we;
        bus.addr  = ADDR_W'(a);
        bus.wdata = d;
        #1;
    endtask

    // One ack cycle returning rdata, then release.
    task automatic ack_once(input logic [31:0] rdata);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        tick();
        bus.mem_ack   = 1'b0;
        #1;
    endtask

    // Compare the logged write-backs against the expected queue.
    task automatic check_wb(input string tag);
        check({tag, "_count"}, 32'(wb_q.size()), 32'(exp_q.size()));
        while (wb_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_addr"}, wb_q.pop_front(), exp_q.pop_front());
        wb_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.re        = 1'b0;
        bus.we        = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
`ifdef DCACHE_FLUSH_EN
        flush         = 1'b0;
`endif
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset values.
        check("rst_stall",     32'(bus.stall),     32'h0);
        check("rst_hit",       32'(bus.cache_hit), 32'h0);
        check("rst_mem_req",   32'(bus.mem_req),   32'h0);
        check("rst_mem_we",    32'(bus.mem_we),    32'h0);
        check("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
        check("rst_mem_wdata", bus.mem_wdata,      32'h0);
        check("rst_rdata",     bus.rdata,          32'h0);
        check("rst_state",     32'(state_dbg),     32'h0);

        // Clean miss on 0x00005.
        drive_req(1'b1, 1'b0, 32'h5, 32'h0);
        check("miss_stall_same_cycle", 32'(bus.stall),     32'h1);
        check("miss_hit_same_cycle",   32'(bus.cache_hit), 32'h0);
        tick();
        check("alloc_mem_req",  32'(bus.mem_req),  32'h1);
        check("alloc_mem_we",   32'(bus.mem_we),   32'h0);
        check("alloc_mem_addr", 32'(bus.mem_addr), 32'h5);
        check("alloc_stall",    32'(bus.stall),    32'h1);
        ack_once(32'hDEADBEEF);
        check("refill_hit",     32'(bus.cache_hit), 32'h1);
        check("refill_rdata",   bus.rdata,          32'hDEADBEEF);
        check("refill_stall",   32'(bus.stall),     32'h0);
        check("refill_req_off", 32'(bus.mem_req),   32'h0);

        // Store hit, then load back with no stall.
        drive_req(1'b0, 1'b1, 32'h5, 32'h12345678);
        check("store_hit",   32'(bus.cache_hit), 32'h1);
        check("store_stall", 32'(bus.stall),     32'h0);
        tick();
        check("store_no_req", 32'(bus.mem_req), 32'h0);
        drive_req(1'b1, 1'b0, 32'h5, 32'h0);
        check("load_after_store_hit",   32'(bus.cache_hit), 32'h1);
        check("load_after_store_rdata", bus.rdata,          32'h12345678);
        check("load_after_store_stall", 32'(bus.stall),     32'h0);

        // Dirty miss on 0x00015 with a 7-cycle delayed write-back ack.
        drive_req(1'b1, 1'b0, 32'h15, 32'h0);
        check("dirty_miss_stall", 32'(bus.stall),     32'h1);
        check("dirty_miss_hit",   32'(bus.cache_hit), 32'h0);
        tick();
        check("wb_mem_req",   32'(bus.mem_req),  32'h1);
        check("wb_mem_we",    32'(bus.mem_we),   32'h1);
        check("wb_mem_addr",  32'(bus.mem_addr), 32'h5);
        check("wb_mem_wdata", bus.mem_wdata,     32'h12345678);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("wb_hold_req",   32'(bus.mem_req),  32'h1);
            check("wb_hold_addr",  32'(bus.mem_addr), 32'h5);
            check("wb_hold_stall", 32'(bus.stall),    32'h1);
        end
        exp_q.push_back(32'h5);
        ack_once(32'h0);
        check("wb2alloc_req",   32'(bus.mem_req),  32'h1);
        check("wb2alloc_we",    32'(bus.mem_we),   32'h0);
        check("wb2alloc_addr",  32'(bus.mem_addr), 32'h15);
        check("wb2alloc_stall", 32'(bus.stall),    32'h1);
        ack_once(32'hCAFE0015);
        check("dirty_refill_hit",   32'(bus.cache_hit), 32'h1);
        check("dirty_refill_rdata", bus.rdata,          32'hCAFE0015);
        check_wb("dirty_wb");

        // Spurious ack in IDLE changes nothing.
        drive_req(1'b0, 1'b0, 32'h15, 32'h0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0BAD0BAD;
        tick();
        bus.mem_ack = 1'b0;
        #1;
        check("spur_mem_req", 32'(bus.mem_req), 32'h0);
        check("spur_stall",   32'(bus.stall),   32'h0);
        check("spur_state",   32'(state_dbg),   32'h0);
        drive_req(1'b1, 1'b0, 32'h15, 32'h0);
        check("spur_reload_hit",   32'(bus.cache_hit), 32'h1);
        check("spur_reload_rdata", bus.rdata,          32'hCAFE0015);

        // Reset during ALLOCATE abandons the refill.
        drive_req(1'b1, 1'b0, 32'h23, 32'h0);
        tick();
        check("pre_rst_req", 32'(bus.mem_req), 32'h1);
        rst_n = 1'b0;
        drive_req(1'b0, 1'b0, 32'h23, 32'h0);
        tick();
        check("mid_rst_req",   32'(bus.mem_req), 32'h0);
        check("mid_rst_stall", 32'(bus.stall),   32'h0);
        rst_n = 1'b1;
        tick();
        drive_req(1'b1, 1'b0, 32'h23, 32'h0);
        check("post_rst_miss_hit",   32'(bus.cache_hit), 32'h0);
        check("post_rst_miss_stall", 32'(bus.stall),     32'h1);
        tick();
        check("post_rst_alloc_addr", 32'(bus.mem_addr), 32'h23);
        ack_once(32'h0000AA23);
        check("post_rst_hit",   32'(bus.cache_hit), 32'h1);
        check("post_rst_rdata", bus.rdata,          32'h0000AA23);

`ifdef DCACHE_FLUSH_EN
        begin
            logic done_seen;
            done_seen = 1'b0;
            // Make lines 2 and 9 resident and dirty.
            drive_req(1'b1, 1'b0, 32'h02, 32'h0);
            tick();
            ack_once(32'h22220000);
            drive_req(1'b0, 1'b1, 32'h02, 32'h2222BEEF);
            tick();
            drive_req(1'b1, 1'b0, 32'h49, 32'h0);
            tick();
            ack_once(32'h99990000);
            drive_req(1'b0, 1'b1, 32'h49, 32'h9999BEEF);
            tick();
            drive_req(1'b0, 1'b0, 32'h0, 32'h0);
            exp_q.push_back(32'h02);
            exp_q.push_back(32'h49);

            flush = 1'b1;
            #1;
            check("flush_stall", 32'(bus.stall), 32'h1);
            tick();
            flush = 1'b0;
            for (int c = 0; c < 200 && !done_seen; c++) begin
                if (flush_done) begin
                    done_seen = 1'b1;
                end else begin
                    bus.mem_ack = bus.mem_req;
                    tick();
                end
            end
            bus.mem_ack = 1'b0;
            #1;
            check("flush_done_seen",  32'(done_seen),    32'h1);
            check("flush_done_stall", 32'(bus.stall),    32'h0);
            tick();
            check("flush_done_single", 32'(flush_done),  32'h0);
            check_wb("flush_wb");
            drive_req(1'b1, 1'b0, 32'h02, 32'h0);
            check("flush_reload_hit",   32'(bus.cache_hit), 32'h1);
            check("flush_reload_rdata", bus.rdata,          32'h2222BEEF);
        end
`endif

        drive_req(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
